// File: rtl/iterative_divider_pkg.sv
// Shared constants for the iterative divider: FSM encodings and default width.
package iterative_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;

endpackage

// File: rtl/ripple_subtractor.sv
// N-bit ripple-borrow subtractor (diff = a - b) built from gate-level full-subtractor cells.
module ripple_subtractor #(
  parameter int unsigned N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  wire [N:0]   borrow;
  wire [N-1:0] d;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit_cell
    wire axb, na, naxb, t_ab, t_bin;
    // d = a ^ b ^ bin ; bout = (~a & b) | (~(a ^ b) & bin)
    xor g_x1 (axb, a[i], b[i]);
    xor g_x2 (d[i], axb, borrow[i]);
    not g_n1 (na, a[i]);
    and g_a1 (t_ab, na, b[i]);
    not g_n2 (naxb, axb);
    and g_a2 (t_bin, naxb, borrow[i]);
    or  g_o1 (borrow[i+1], t_ab, t_bin);
  end

  assign diff       = d;
  assign borrow_out = borrow[N];

endmodule

// File: rtl/iterative_divider.sv
// Restoring radix-2 divider, one quotient bit per cycle, signed (DIV) or unsigned (DIVU).
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             sgn_q, sgn_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             zero_q, zero_d;
  logic             busy_d, done_d, dbz_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_borrow;
  logic             unused_trial_msb;

  // Partial remainder shifted left with the next dividend bit entering at the LSB.
  assign shifted = {rem_q, quo_q[WIDTH-1]};

  ripple_subtractor #(.N(WIDTH + 1)) u_trial_sub (
    .a          (shifted),
    .b          ({1'b0, dsr_q}),
    .diff       (trial),
    .borrow_out (trial_borrow)
  );

  // A non-negative trial is always below the divisor, so its top bit carries no information.
  assign unused_trial_msb = trial[WIDTH];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      sgn_q       <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      zero_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      sgn_q       <= sgn_d;
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      zero_q      <= zero_d;
      busy        <= busy_d;
      done        <= done_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    sgn_d       = sgn_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    zero_d      = zero_q;
    busy_d      = busy;
    done_d      = 1'b0;
    quotient_d  = quotient;
    remainder_d = remainder;
    dbz_d       = div_by_zero;

    case (state_q)
      IDLE: begin
        // The done cycle is also IDLE; a start there is deliberately dropped.
        if (start && !done) begin
          sgn_d   = is_signed;
          neg_a_d = is_signed & dividend[WIDTH-1];
          neg_b_d = is_signed & divisor[WIDTH-1];
          dsr_d   = (is_signed && divisor[WIDTH-1]) ? (WIDTH'(0) - divisor) : divisor;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          if (divisor == '0) begin
            zero_d  = 1'b1;
            quo_d   = dividend;
            state_d = SIGN;
          end else begin
            zero_d  = 1'b0;
            quo_d   = (is_signed && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (trial_borrow) begin
          rem_d = shifted[WIDTH-1:0];
        end else begin
          rem_d = trial[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], ~trial_borrow};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = SIGN;
        end
      end

      SIGN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = quo_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = (sgn_q && (neg_a_q != neg_b_q)) ? (WIDTH'(0) - quo_q) : quo_q;
          remainder_d = (sgn_q && neg_a_q) ? (WIDTH'(0) - rem_q) : rem_q;
          dbz_d       = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed corner cases plus random operands vs. an arithmetic model.
module tb_iterative_divider;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  iterative_divider #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero for signed operands.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  // Launch one division at the current negedge and check latency, busy span, results and hold.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb);
    logic [31:0] eq, er;
    logic        ez;
    int          n, nb, lat;
    model(s, a, b, eq, er, ez);
    lat       = (b == 32'd0) ? 1 : 33;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    n  = 0;
    nb = 0;
    do begin
      @(negedge clock);
      n++;
      if (busy) nb++;
      start = disturb && (n == 10);
      if (n >= 2) begin
        dividend  = ~a ^ 32'(n);
        divisor   = a + 32'(n);
        is_signed = ~s;
      end
    end while (!done && n < 200);
    check({tag, ".done_seen"}, 32'(done), 32'd1);
    check({tag, ".latency"}, 32'(n - 1), 32'(lat));
    check({tag, ".busy_cycles"}, 32'(nb), 32'(lat));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(ez));
    start    = 1'b1;
    dividend = a ^ 32'h5A5A_5A5A;
    divisor  = b + 32'd1;
    @(negedge clock);
    start = 1'b0;
    check({tag, ".ignored_busy"}, 32'(busy), 32'd0);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    @(negedge clock);
    check({tag, ".hold_q"}, quotient, eq);
    check({tag, ".hold_r"}, remainder, er);
    check({tag, ".hold_z"}, 32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    int          sel;

    reset_n   = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clock);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.quotient", quotient, 32'd0);
    check("rst.remainder", remainder, 32'd0);
    check("rst.dbz", 32'(div_by_zero), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run_op("udiv_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    check("udiv_100_7.q_const", quotient, 32'd14);
    check("udiv_100_7.r_const", remainder, 32'd2);
    run_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("sdiv_m7_2.q_const", quotient, 32'hFFFF_FFFD);
    check("sdiv_m7_2.r_const", remainder, 32'hFFFF_FFFF);
    run_op("div0_u", 1'b0, 32'h1234_5678, 32'd0, 1'b0);
    check("div0_u.r_const", remainder, 32'h1234_5678);
    run_op("div0_s", 1'b1, 32'h8765_4321, 32'd0, 1'b0);
    run_op("sdiv_minneg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("sdiv_minneg.q_const", quotient, 32'h8000_0000);
    check("sdiv_minneg.r_const", remainder, 32'd0);
    run_op("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    check("udiv_max_1.q_const", quotient, 32'hFFFF_FFFF);
    run_op("udiv_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("sdiv_neg_neg", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);

    // Reset in the middle of a division discards it.
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.quotient", quotient, 32'd0);
    check("midrst.remainder", remainder, 32'd0);
    check("midrst.dbz", 32'(div_by_zero), 32'd0);
    @(negedge clock);
    check("midrst.done2", 32'(done), 32'd0);
    reset_n = 1'b1;
    run_op("after_rst", 1'b1, 32'hFFFF_FC18, 32'd33, 1'b0);

    for (int i = 0; i < 40; i++) begin
      s   = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rand%0d", i), s, a, b, (i % 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = two's-complement division (DIV), 0 = unsigned (DIVU); latched with start.
REQ-006 dividend  input  WIDTH  numerator; latched with start.
REQ-007 divisor  input  WIDTH  denominator; latched with start.
REQ-008 busy  output  1  high from the cycle after start is accepted until done is high.
REQ-009 done  output  1  one-cycle pulse; results are valid from this cycle.
REQ-010 quotient  output  WIDTH  result, destined for LO.
REQ-011 remainder  output  WIDTH  result, destined for HI.
REQ-012 div_by_zero  output  1  flag for the last completed operation, valid with done.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, SIGN.
- IDLE -> CALC on start=1 and divisor!=0.
- IDLE -> SIGN on start=1 and divisor==0.
- CALC -> SIGN after exactly WIDTH iterations.
- SIGN -> IDLE unconditionally.
REQ-014 On acceptance, the block SHALL latch the operand magnitudes and record the sign of each operand.
- Magnitude = two's-complement negation when is_signed=1 and the operand MSB=1.
- Magnitude = raw value otherwise.
REQ-015 CALC SHALL perform one restoring step per cycle, MSB first.
- Shift {partial_remainder, dividend_magnitude} left by 1.
- Compute trial = partial_remainder - divisor_magnitude, WIDTH+1 bits.
- If trial is non-negative: keep trial as the partial remainder and shift in quotient bit 1.
- Otherwise: restore the partial remainder and shift in quotient bit 0.
REQ-016 SIGN SHALL apply the sign rules and register the outputs.
- Quotient is negated when is_signed=1 and the operand signs differ.
- Remainder is negated when is_signed=1 and the dividend is negative.
- done=1 in the cycle SIGN returns to IDLE.
REQ-017 Latency SHALL be fixed: start sampled at edge 0 -> done high in the cycle after edge WIDTH+1 (33 for WIDTH=32). busy SHALL be high for exactly WIDTH+1 cycles.
REQ-018 Divisor zero SHALL give the following, with done one cycle after acceptance:
- quotient = all ones;
- remainder = dividend (raw);
- div_by_zero = 1.
REQ-019 Signed most-negative / -1 SHALL give quotient = most-negative value, remainder = 0, div_by_zero = 0; no trap is raised.
REQ-020 start asserted while busy=1 or in the done cycle SHALL be ignored; input changes during busy SHALL NOT affect the result.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values until the next done.

Reset
REQ-022 reset_n=0 at a clock edge SHALL force the following, overriding any operation in progress (the aborted result is discarded):
- state IDLE;
- busy=0, done=0, quotient=0, remainder=0, div_by_zero=0;
- iteration counter=0.
REQ-023 start asserted in the first cycle after reset_n rises SHALL be accepted normally.

Structure
REQ-024 The shared definitions file SHALL hold the state encodings (IDLE=2'd0, CALC=2'd1, SIGN=2'd2) and the default width constant.
REQ-025 The trial subtraction SHALL be a sub-module ripple_subtractor (WIDTH+1 bits; a - b plus a borrow-out), built from a full-subtractor bit cell using the existing gate library.
REQ-026 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-027 Unsigned 100 / 7 -> done 33 cycles after start; quotient=14, remainder=2, div_by_zero=0.
REQ-028 Signed -7 / 2 (0xFFFFFFF9 / 2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
REQ-029 Any / 0, dividend 0x12345678 -> done one cycle after acceptance; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
REQ-030 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-031 Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0. A second start pulse with different operands at cycle 10 is ignored and the result is unchanged.
REQ-032 reset_n low at cycle 15 of a division -> next cycle busy=0, all outputs 0, no done. A new start after reset gives correct results.
